// File: rtl/stack_alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the stack ALU and its operand stack.
// Also holds the helper that says how many stack entries an opcode consumes.
package definitions;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_POP  = 4'd2,
        OP_ADD  = 4'd3,
        OP_ADC  = 4'd4,
        OP_SUB  = 4'd5,
        OP_INC  = 4'd6,
        OP_ABS  = 4'd7,
        OP_BLT  = 4'd8,
        OP_CON  = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_CLRC = 4'd12
    } alu_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of operands an opcode reads from the stack; PUSH is checked separately for fullness.
    function automatic logic [1:0] op_needs(input alu_op_t op);
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_BLT, OP_CON: op_needs = 2'd2;
            OP_POP, OP_ABS, OP_SHL, OP_SHR:         op_needs = 2'd1;
            default:                                op_needs = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu_seq_op_stack.sv
// Register-array LIFO. One combined update per cycle (pop/pop2, then push, or replace_top).
// No error checking: the parent only requests legal updates.
module op_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         pop2,
    input  logic                         replace_top,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 s0,
    output logic [W-1:0]                 s1,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d, base;
    logic [IW-1:0] top_idx, nxt_idx, wr_idx;

    always_comb begin
        top_idx = IW'(depth_q - DW'(1));
        nxt_idx = IW'(depth_q - DW'(2));
        s0 = (depth_q >= DW'(1)) ? mem_q[top_idx] : '0;
        s1 = (depth_q >= DW'(2)) ? mem_q[nxt_idx] : '0;
    end

    // Pops retire first, so a pop2+push (binary op) writes the result where s1 lived.
    always_comb begin
        mem_d = mem_q;
        base  = depth_q;
        if (pop)  base = base - DW'(1);
        if (pop2) base = base - DW'(2);
        depth_d = base;
        wr_idx  = IW'(base);
        if (push) begin
            mem_d[wr_idx] = wdata;
            depth_d       = base + DW'(1);
        end
        if (replace_top) mem_d[top_idx] = wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) depth_q <= '0;
        else       depth_q <= depth_d;
        mem_q <= mem_d;
    end

    assign depth = depth_q;

endmodule

// File: rtl/stack_alu_seq.sv
// Sequential stack-operand ALU: operand stack, persistent carry, bit-serial shifts
// and explicit stack-error reporting, one op accepted per valid/ready handshake.
module stack_alu_seq
    import definitions::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3:0]                   op,
    input  logic [W-1:0]                 reg_val,
    output logic                         result_valid,
    output logic [W-1:0]                 reg_out,
    output logic                         branch_sig,
    output logic                         err,
    output logic                         carry,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(W + 1);
    localparam int SH_MOD_I = W + 1;
    localparam logic [W-1:0]  SH_MOD = SH_MOD_I[W-1:0];
    localparam logic [DW-1:0] FULL   = DW'(DEPTH);

    // Handshake: an op transfers on a rising edge where op_valid && op_ready; op_ready is
    // low during reset and while a shift is in flight, and the decoder must hold op_valid.
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d, sh_next;
    logic          dir_q, dir_d;
    logic          carry_q, carry_d, branch_q, branch_d, err_q, err_d, rv_q, rv_d;
    logic [W-1:0]  reg_out_q, reg_out_d;

    alu_op_t       op_e;
    logic          accept, bad, con_hit;
    logic [1:0]    needs;
    logic [W:0]    sum;
    logic [W-1:0]  n_full, r, s0, s1;
    logic [CW-1:0] n;
    logic          st_push, st_pop, st_pop2, st_repl;
    logic [W-1:0]  st_wdata;

    op_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .clk(clk), .reset(reset), .push(st_push), .pop(st_pop), .pop2(st_pop2),
        .replace_top(st_repl), .wdata(st_wdata), .s0(s0), .s1(s1), .depth(depth)
    );

    assign op_e     = alu_op_t'(op);
    assign op_ready = (st_q == ST_IDLE) && !reset;
    assign accept   = op_valid && op_ready;
    assign needs    = op_needs(op_e);
    assign n_full   = reg_val % SH_MOD;
    assign n        = n_full[CW-1:0];
    assign sum      = {1'b0, s0} + {1'b0, s1} + {{W{1'b0}}, carry_q & (op_e == OP_ADC)};
    assign sh_next  = dir_q ? (sh_q >> 1) : (sh_q << 1);
    assign bad      = ((needs == 2'd2) && (depth < DW'(2))) ||
                      ((needs == 2'd1) && (depth == '0)) ||
                      ((op_e == OP_PUSH) && (depth == FULL));

    // CON: does the low half of s1 appear in any W/2-bit window of s0?
    always_comb begin
        con_hit = 1'b0;
        for (int k = 0; k <= W / 2; k++) begin
            if (s0[k +: W/2] == s1[W/2-1:0]) con_hit = 1'b1;
        end
    end

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        dir_d     = dir_q;
        carry_d   = carry_q;
        reg_out_d = reg_out_q;
        branch_d  = 1'b0;
        err_d     = 1'b0;
        rv_d      = 1'b0;
        r         = '0;
        st_push   = 1'b0;
        st_pop    = 1'b0;
        st_pop2   = 1'b0;
        st_repl   = 1'b0;
        st_wdata  = '0;
        if (st_q == ST_SHIFT) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                st_d      = ST_IDLE;
                st_repl   = 1'b1;
                st_wdata  = sh_next;
                reg_out_d = sh_next;
                rv_d      = 1'b1;
            end
        end else if (accept) begin
            if (bad) begin
                rv_d  = 1'b1;
                err_d = 1'b1;
            end else begin
                case (op_e)
                    OP_PUSH: begin
                        st_push = 1'b1; st_wdata = reg_val; reg_out_d = reg_val; rv_d = 1'b1;
                    end
                    OP_POP: begin
                        st_pop = 1'b1; reg_out_d = s0; rv_d = 1'b1;
                    end
                    OP_ADD, OP_ADC: begin
                        {carry_d, r} = sum;
                        st_pop2 = 1'b1; st_push = 1'b1; st_wdata = r; reg_out_d = r; rv_d = 1'b1;
                    end
                    OP_SUB: begin
                        r = s0 - s1; carry_d = (s0 < s1);
                        st_pop2 = 1'b1; st_push = 1'b1; st_wdata = r; reg_out_d = r; rv_d = 1'b1;
                    end
                    OP_INC: begin
                        reg_out_d = reg_val + W'(1); rv_d = 1'b1;
                    end
                    OP_ABS: begin
                        r = s0[W-1] ? (~s0 + W'(1)) : s0;
                        st_repl = 1'b1; st_wdata = r; reg_out_d = r; rv_d = 1'b1;
                    end
                    OP_BLT: begin
                        branch_d = (s0 < s1); st_pop2 = 1'b1; rv_d = 1'b1;
                    end
                    OP_CON: begin
                        branch_d = con_hit; st_pop2 = 1'b1; rv_d = 1'b1;
                    end
                    OP_SHL, OP_SHR: begin
                        if (n == '0) begin
                            reg_out_d = s0; rv_d = 1'b1;
                        end else begin
                            st_d = ST_SHIFT; cnt_d = n; sh_d = s0; dir_d = (op_e == OP_SHR);
                        end
                    end
                    OP_CLRC: carry_d = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            dir_q     <= 1'b0;
            carry_q   <= 1'b0;
            reg_out_q <= '0;
            branch_q  <= 1'b0;
            err_q     <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            dir_q     <= dir_d;
            carry_q   <= carry_d;
            reg_out_q <= reg_out_d;
            branch_q  <= branch_d;
            err_q     <= err_d;
            rv_q      <= rv_d;
        end
    end

    assign result_valid = rv_q;
    assign reg_out      = reg_out_q;
    assign branch_sig   = branch_q;
    assign err          = err_q;
    assign carry        = carry_q;

endmodule

// File: tb/tb_stack_alu_seq.sv
// Directed bench for stack_alu_seq: hand-computed vectors for arithmetic, carry chaining,
// shifts (including reset mid-shift), stack errors, CON/BLT branches, ABS and INC throughput.
module tb_stack_alu_seq;
    localparam int W     = 8;
    localparam int DEPTH = 8;

    localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, ADD = 4'd3, ADC = 4'd4;
    localparam logic [3:0] SUB = 4'd5, INC = 4'd6, ABS = 4'd7, BLT = 4'd8, CON = 4'd9;
    localparam logic [3:0] SHL = 4'd10, SHR = 4'd11, CLRC = 4'd12;

    logic         clk = 1'b0;
    logic         reset, op_valid, op_ready, result_valid, branch_sig, err, carry;
    logic [3:0]   op;
    logic [W-1:0] reg_val, reg_out;
    logic [3:0]   depth;

    int checks   = 0;
    int failures = 0;
    int cyc, lows, seen;

    stack_alu_seq #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .reg_val(reg_val), .result_valid(result_valid), .reg_out(reg_out),
        .branch_sig(branch_sig), .err(err), .carry(carry), .depth(depth)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] v);
        op_valid = 1'b1;
        op       = o;
        reg_val  = v;
        tick();
        op_valid = 1'b0;
        op       = NOP;
        reg_val  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Counts cycles from the one after acceptance until result_valid, bounded.
    task automatic wait_result(output int c, output int l);
        c = 1;
        l = 0;
        while (!result_valid && c < 20) begin
            if (!op_ready) l++;
            tick();
            c++;
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = NOP; reg_val = '0;
        tick();
        tick();
        check_eq("rst_op_ready", op_ready, 0);
        check_eq("rst_depth", depth, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_reg_out", reg_out, 0);
        check_eq("rst_rv", result_valid, 0);
        check_eq("rst_err", err, 0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", op_ready, 1);

        issue(PUSH, 8'h70);
        check_eq("push_rv", result_valid, 1);
        check_eq("push_out", reg_out, 8'h70);
        issue(PUSH, 8'hA0);
        issue(ADD, 8'h00);
        check_eq("add_rv", result_valid, 1);
        check_eq("add_out", reg_out, 8'h10);
        check_eq("add_carry", carry, 1);
        check_eq("add_depth", depth, 1);
        check_eq("add_err", err, 0);
        issue(PUSH, 8'h01);
        issue(PUSH, 8'h02);
        issue(ADC, 8'h00);
        check_eq("adc_out", reg_out, 8'h04);
        check_eq("adc_carry", carry, 0);
        check_eq("adc_depth", depth, 2);

        do_reset();
        check_eq("reset2_depth", depth, 0);
        issue(PUSH, 8'd3);
        issue(PUSH, 8'd5);
        issue(SUB, 8'h00);
        check_eq("sub1_out", reg_out, 8'h02);
        check_eq("sub1_carry", carry, 0);
        issue(PUSH, 8'd5);
        issue(PUSH, 8'd3);
        issue(SUB, 8'h00);
        check_eq("sub2_out", reg_out, 8'hFE);
        check_eq("sub2_carry", carry, 1);
        issue(INC, 8'hFF);
        check_eq("inc_wrap_out", reg_out, 8'h00);
        check_eq("inc_keeps_carry", carry, 1);
        issue(CLRC, 8'h00);
        check_eq("clrc_carry", carry, 0);
        check_eq("clrc_no_result", result_valid, 0);

        do_reset();
        issue(PUSH, 8'h81);
        issue(SHL, 8'd3);
        wait_result(cyc, lows);
        check_eq("shl_rv", result_valid, 1);
        check_eq("shl_latency", cyc, 4);
        check_eq("shl_ready_low", lows, 3);
        check_eq("shl_out", reg_out, 8'h08);
        check_eq("shl_ready_back", op_ready, 1);
        check_eq("shl_depth", depth, 1);

        issue(PUSH, 8'h81);
        issue(SHL, 8'd3);
        tick();
        reset = 1'b1;
        tick();
        check_eq("midshift_ready_in_rst", op_ready, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid) seen++;
        end
        check_eq("midshift_no_result", seen, 0);
        check_eq("midshift_depth", depth, 0);
        check_eq("midshift_reg_out", reg_out, 0);
        check_eq("midshift_ready", op_ready, 1);

        issue(POP, 8'h00);
        check_eq("pop_empty_rv", result_valid, 1);
        check_eq("pop_empty_err", err, 1);
        check_eq("pop_empty_depth", depth, 0);
        check_eq("pop_empty_branch", branch_sig, 0);
        for (int i = 0; i < DEPTH; i++) issue(PUSH, W'(i + 1));
        check_eq("fill_depth", depth, DEPTH);
        issue(PUSH, 8'h55);
        check_eq("push_full_err", err, 1);
        check_eq("push_full_depth", depth, DEPTH);
        check_eq("push_full_out", reg_out, 8'h08);
        issue(POP, 8'h00);
        check_eq("pop_after_full", reg_out, 8'h08);
        check_eq("pop_after_full_err", err, 0);

        do_reset();
        issue(PUSH, 8'h0A);
        issue(PUSH, 8'h5A);
        issue(CON, 8'h00);
        check_eq("con_hit", branch_sig, 1);
        check_eq("con_depth", depth, 0);
        issue(PUSH, 8'h0F);
        issue(PUSH, 8'h5A);
        issue(CON, 8'h00);
        check_eq("con_miss", branch_sig, 0);
        check_eq("con_miss_rv", result_valid, 1);
        issue(PUSH, 8'd9);
        issue(PUSH, 8'd4);
        issue(BLT, 8'h00);
        check_eq("blt_taken", branch_sig, 1);
        check_eq("blt_out_held", reg_out, 8'h04);
        check_eq("blt_depth", depth, 0);
        issue(ADD, 8'h00);
        check_eq("add_empty_err", err, 1);

        issue(PUSH, 8'h80);
        issue(ABS, 8'h00);
        check_eq("abs_minneg_out", reg_out, 8'h80);
        check_eq("abs_minneg_err", err, 0);
        issue(PUSH, 8'hFB);
        issue(ABS, 8'h00);
        check_eq("abs_neg_out", reg_out, 8'h05);
        check_eq("abs_depth", depth, 2);

        issue(SHR, 8'd9);
        check_eq("shr_n0_rv", result_valid, 1);
        check_eq("shr_n0_out", reg_out, 8'h05);
        issue(SHR, 8'd11);
        wait_result(cyc, lows);
        check_eq("shr2_latency", cyc, 3);
        check_eq("shr2_out", reg_out, 8'h01);
        issue(POP, 8'h00);
        check_eq("shr2_stack_top", reg_out, 8'h01);

        op_valid = 1'b1;
        op       = INC;
        for (int i = 0; i < 5; i++) begin
            reg_val = W'(i * 16 + 3);
            tick();
            check_eq("inc_b2b_rv", result_valid, 1);
            check_eq("inc_b2b_out", reg_out, i * 16 + 4);
        end
        op_valid = 1'b0;
        op       = NOP;
        tick();
        check_eq("inc_b2b_end", result_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
